// File: rtl/reg_bank_initiator_pkg.sv
// reg_bank_initiator_pkg: command op codes and FSM states shared by the initiator and its users
package reg_bank_initiator_pkg;
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FILL,
        S_RESP
    } state_e;
endpackage

// File: rtl/reg_bank_initiator_if.sv
// reg_bank_initiator_if: command, response and bank-port signals between initiator and its environment
interface reg_bank_initiator_if
    import reg_bank_initiator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);
    logic             cmd_valid;
    logic             cmd_ready;
    op_e              cmd_op;
    logic [AW-1:0]    cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic [AW-1:0]    bank_addr;
    logic             bank_write_en;
    logic [WIDTH-1:0] bank_data_in;
    logic [WIDTH-1:0] bank_data_out;
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, bank_data_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, bank_addr, bank_write_en, bank_data_in
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, bank_data_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, bank_addr, bank_write_en, bank_data_in
    );
endinterface

// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH register file, synchronous write, combinational read, own reset
module register_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    addr,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             in_range;
    assign in_range = {1'b0, addr} < (AW + 1)'(DEPTH);
    assign data_out = in_range ? mem_q[addr] : '0;
    // Next contents: only an in-range write changes an entry
    always_comb begin
        mem_d = mem_q;
        if (write_en && in_range) mem_d[addr] = data_in;
    end
    // Storage registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/reg_bank_initiator.sv
// reg_bank_initiator: turns READ/WRITE/FILL commands into register_bank port cycles, one response per command
module reg_bank_initiator
    import reg_bank_initiator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    reg_bank_initiator_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    bank_addr_q, bank_addr_d;
    logic [WIDTH-1:0] bank_data_in_q, bank_data_in_d;
    logic             bank_we_q, bank_we_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             cmd_err;

    // Reserved op, or an address past the last entry on READ/WRITE; FILL ignores cmd_addr
    assign cmd_err = bus.cmd_op == OP_RSVD || (bus.cmd_op != OP_FILL && {1'b0, bus.cmd_addr} >= DEPTH_W);

    assign bus.cmd_ready     = state_q == S_IDLE;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.bank_addr     = bank_addr_q;
    assign bus.bank_write_en = bank_we_q;
    assign bus.bank_data_in  = bank_data_in_q;

    // State and output registers; reset abandons any command and drops a pending response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            bank_addr_q    <= '0;
            bank_data_in_q <= '0;
            bank_we_q      <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bank_addr_q    <= bank_addr_d;
            bank_data_in_q <= bank_data_in_d;
            bank_we_q      <= bank_we_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    // Next state: one bank cycle for READ/WRITE, DEPTH cycles for FILL, straight to RESP on error
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = cmd_err ? S_RESP :
                              bus.cmd_op == OP_WRITE ? S_WRITE :
                              bus.cmd_op == OP_READ ? S_READ : S_FILL;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_READ:  state_d = S_RESP;
            S_FILL:  state_d = bank_addr_q == LAST ? S_RESP : S_FILL;
            S_RESP:  state_d = bus.rsp_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the next cycle; bank address/data hold when idle, write enable qualifies them
    always_comb begin
        bank_addr_d    = bank_addr_q;
        bank_data_in_d = bank_data_in_q;
        bank_we_d      = bank_we_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_err) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else if (bus.cmd_valid) begin
                    bank_addr_d    = bus.cmd_op == OP_FILL ? '0 : bus.cmd_addr;
                    bank_data_in_d = bus.cmd_op == OP_READ ? bank_data_in_q : bus.cmd_wdata;
                    bank_we_d      = bus.cmd_op != OP_READ;
                end
            end
            S_WRITE: begin
                bank_we_d   = 1'b0;
                rsp_data_d  = '0;
                rsp_valid_d = 1'b1;
            end
            S_READ: begin
                rsp_data_d  = bus.bank_data_out;
                rsp_valid_d = 1'b1;
            end
            S_FILL: begin
                if (bank_addr_q == LAST) begin
                    bank_we_d   = 1'b0;
                    rsp_data_d  = bank_data_in_q;
                    rsp_valid_d = 1'b1;
                end else begin
                    bank_addr_d    = bank_addr_q + 1'b1;
                    bank_data_in_d = bank_data_in_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: bank_we_d = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_reg_bank_initiator.sv
// tb_reg_bank_initiator: directed tests of the initiator driving real register_bank instances (DEPTH 4 and 6)
module tb_reg_bank_initiator;
    import reg_bank_initiator_pkg::*;

    logic clk = 1'b0;
    logic reset, reset6, bank_reset;
    int   errors = 0;
    int   checks = 0;
    int   we6_cnt = 0;

    reg_bank_initiator_if #(.WIDTH(8), .DEPTH(4)) if4 ();
    reg_bank_initiator_if #(.WIDTH(8), .DEPTH(6)) if6 ();

    reg_bank_initiator #(.WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    reg_bank_initiator #(.WIDTH(8), .DEPTH(6)) dut6 (.clk(clk), .reset(reset6), .bus(if6));

    register_bank #(.WIDTH(8), .DEPTH(4)) bank4 (
        .clk(clk), .reset(bank_reset), .addr(if4.bank_addr), .write_en(if4.bank_write_en),
        .data_in(if4.bank_data_in), .data_out(if4.bank_data_out)
    );
    register_bank #(.WIDTH(8), .DEPTH(6)) bank6 (
        .clk(clk), .reset(bank_reset), .addr(if6.bank_addr), .write_en(if6.bank_write_en),
        .data_in(if6.bank_data_in), .data_out(if6.bank_data_out)
    );

    always #5 clk = ~clk;

    // Counts every cycle the DEPTH=6 initiator writes its bank; error commands must never do so
    always @(posedge clk) if (if6.bank_write_en) we6_cnt <= we6_cnt + 1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input op_e op, input logic [1:0] a, input logic [7:0] d);
        if4.cmd_op    = op;
        if4.cmd_addr  = a;
        if4.cmd_wdata = d;
        if4.cmd_valid = 1'b1;
        cyc();
        if4.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!if4.rsp_valid && n < 50) begin
            cyc();
            n++;
        end
        if (!if4.rsp_valid) n = -1;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [7:0] d, output int n);
        send(OP_READ, a, 8'h00);
        wait_rsp(n);
        d = if4.rsp_data;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reset6 = 1'b1;
        bank_reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if (if4.cmd_ready !== 1'b1 || if4.rsp_valid !== 1'b0 || if4.rsp_err !== 1'b0)
            begin errors++; $display("FAIL reset_handshake: ready=%b valid=%b err=%b want 1 0 0", if4.cmd_ready, if4.rsp_valid, if4.rsp_err); end
        checks++;
        if (if4.rsp_data !== 8'h00 || if4.bank_addr !== 2'd0 || if4.bank_write_en !== 1'b0 || if4.bank_data_in !== 8'h00)
            begin errors++; $display("FAIL reset_regs: data=%h addr=%0d we=%b din=%h want 00 0 0 00", if4.rsp_data, if4.bank_addr, if4.bank_write_en, if4.bank_data_in); end
        checks++;
        if (if6.cmd_ready !== 1'b1 || if6.rsp_valid !== 1'b0)
            begin errors++; $display("FAIL reset_d6: ready=%b valid=%b want 1 0", if6.cmd_ready, if6.rsp_valid); end
        reset = 1'b0;
        reset6 = 1'b0;
        bank_reset = 1'b0;
        cyc();
    endtask

    task automatic test_write_read();
        int n;
        logic [7:0] d;
        send(OP_WRITE, 2'd1, 8'hAA);
        checks++;
        if (if4.bank_write_en !== 1'b1 || if4.bank_addr !== 2'd1 || if4.bank_data_in !== 8'hAA)
            begin errors++; $display("FAIL write_drive: we=%b addr=%0d din=%h want 1 1 aa", if4.bank_write_en, if4.bank_addr, if4.bank_data_in); end
        wait_rsp(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL write_latency: got %0d want 1", n); end
        checks++;
        if (if4.rsp_data !== 8'h00 || if4.rsp_err !== 1'b0 || if4.bank_write_en !== 1'b0)
            begin errors++; $display("FAIL write_rsp: data=%h err=%b we=%b want 00 0 0", if4.rsp_data, if4.rsp_err, if4.bank_write_en); end
        cyc();
        checks++;
        if (if4.rsp_valid !== 1'b0 || if4.cmd_ready !== 1'b1)
            begin errors++; $display("FAIL write_done: valid=%b ready=%b want 0 1", if4.rsp_valid, if4.cmd_ready); end
        do_read(2'd1, d, n);
        checks++;
        if (n !== 1 || d !== 8'hAA) begin errors++; $display("FAIL read_1: lat=%0d data=%h want 1 aa", n, d); end
    endtask

    task automatic test_fill();
        int n;
        logic [7:0] d;
        send(OP_FILL, 2'd3, 8'h10);
        wait_rsp(n);
        checks++;
        if (n !== 4 || if4.rsp_data !== 8'h13 || if4.rsp_err !== 1'b0)
            begin errors++; $display("FAIL fill_rsp: lat=%0d data=%h err=%b want 4 13 0", n, if4.rsp_data, if4.rsp_err); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i), d, n);
            checks++;
            if (d !== 8'h10 + 8'(i)) begin errors++; $display("FAIL fill_entry%0d: got %h want %h", i, d, 8'h10 + 8'(i)); end
        end
    endtask

    task automatic test_fill_wrap();
        int n;
        logic [7:0] d;
        logic [7:0] exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        send(OP_FILL, 2'd0, 8'hFE);
        wait_rsp(n);
        checks++;
        if (n !== 4 || if4.rsp_data !== 8'h01)
            begin errors++; $display("FAIL wrap_rsp: lat=%0d data=%h want 4 01", n, if4.rsp_data); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i), d, n);
            checks++;
            if (d !== exp[i]) begin errors++; $display("FAIL wrap_entry%0d: got %h want %h", i, d, exp[i]); end
        end
    endtask

    task automatic test_stall();
        int n;
        logic [7:0] d;
        if4.rsp_ready = 1'b0;
        send(OP_WRITE, 2'd2, 8'h55);
        wait_rsp(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL stall_latency: got %0d want 1", n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (if4.rsp_valid !== 1'b1 || if4.rsp_data !== 8'h00 || if4.cmd_ready !== 1'b0)
                begin errors++; $display("FAIL stall_hold%0d: valid=%b data=%h ready=%b want 1 00 0", i, if4.rsp_valid, if4.rsp_data, if4.cmd_ready); end
            cyc();
        end
        if4.rsp_ready = 1'b1;
        cyc();
        checks++;
        if (if4.rsp_valid !== 1'b0 || if4.cmd_ready !== 1'b1)
            begin errors++; $display("FAIL stall_release: valid=%b ready=%b want 0 1", if4.rsp_valid, if4.cmd_ready); end
        do_read(2'd2, d, n);
        checks++;
        if (d !== 8'h55) begin errors++; $display("FAIL stall_read: got %h want 55", d); end
    endtask

    task automatic test_reset_fill();
        int n;
        logic [7:0] d;
        logic [7:0] exp [4] = '{8'h20, 8'h21, 8'h55, 8'h01};
        send(OP_FILL, 2'd0, 8'h20);
        cyc();
        checks++;
        if (if4.bank_write_en !== 1'b1 || if4.bank_addr !== 2'd1 || if4.bank_data_in !== 8'h21)
            begin errors++; $display("FAIL rfill_progress: we=%b addr=%0d din=%h want 1 1 21", if4.bank_write_en, if4.bank_addr, if4.bank_data_in); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (if4.bank_write_en !== 1'b0 || if4.rsp_valid !== 1'b0 || if4.cmd_ready !== 1'b1)
            begin errors++; $display("FAIL rfill_abort: we=%b valid=%b ready=%b want 0 0 1", if4.bank_write_en, if4.rsp_valid, if4.cmd_ready); end
        cyc();
        cyc();
        checks++;
        if (if4.rsp_valid !== 1'b0) begin errors++; $display("FAIL rfill_no_rsp: valid=%b want 0", if4.rsp_valid); end
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i), d, n);
            checks++;
            if (d !== exp[i]) begin errors++; $display("FAIL rfill_entry%0d: got %h want %h", i, d, exp[i]); end
        end
    endtask

    task automatic test_error();
        logic [2:0] addrs [2] = '{3'd7, 3'd0};
        op_e        ops   [2] = '{OP_READ, OP_RSVD};
        if6.rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if6.cmd_op    = ops[i];
            if6.cmd_addr  = addrs[i];
            if6.cmd_wdata = 8'h5A;
            if6.cmd_valid = 1'b1;
            cyc();
            if6.cmd_valid = 1'b0;
            checks++;
            if (if6.rsp_valid !== 1'b1 || if6.rsp_err !== 1'b1 || if6.rsp_data !== 8'h00)
                begin errors++; $display("FAIL err%0d_rsp: valid=%b err=%b data=%h want 1 1 00", i, if6.rsp_valid, if6.rsp_err, if6.rsp_data); end
            cyc();
            checks++;
            if (if6.rsp_valid !== 1'b0 || if6.rsp_err !== 1'b0 || if6.cmd_ready !== 1'b1)
                begin errors++; $display("FAIL err%0d_done: valid=%b err=%b ready=%b want 0 0 1", i, if6.rsp_valid, if6.rsp_err, if6.cmd_ready); end
        end
        checks++;
        if (we6_cnt !== 0) begin errors++; $display("FAIL err_no_write: write cycles=%0d want 0", we6_cnt); end
    endtask

    initial begin
        if4.cmd_valid = 1'b0;
        if4.cmd_op    = OP_READ;
        if4.cmd_addr  = '0;
        if4.cmd_wdata = '0;
        if4.rsp_ready = 1'b1;
        if6.cmd_valid = 1'b0;
        if6.cmd_op    = OP_READ;
        if6.cmd_addr  = '0;
        if6.cmd_wdata = '0;
        if6.rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_fill();
        test_fill_wrap();
        test_stall();
        test_reset_fill();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
